// File: rtl/lc3_pkg.sv
// lc3_pkg: shared address map and controller FSM state for the LC-3 memory controller.
package lc3_pkg;
    localparam logic [15:0] IO_BASE   = 16'hFE00;
    localparam logic [15:0] KBSR_ADDR = 16'hFE00;
    localparam logic [15:0] KBDR_ADDR = 16'hFE02;
    localparam logic [15:0] DSR_ADDR  = 16'hFE04;
    localparam logic [15:0] DDR_ADDR  = 16'hFE06;
    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
endpackage

// File: rtl/lc3_io_regs.sv
// lc3_io_regs: LC-3 KBSR/KBDR/DSR/DDR device registers with keyboard and display stream handshakes.
// Ports: clk, rst (async active-low); i_rd/i_wr strobes with i_addr/i_wdata, o_rdata read mux;
//        keyboard i_kb_valid/i_kb_data/o_kb_ready, o_kb_irq; display o_dsp_valid/o_dsp_data/i_dsp_ready.
module lc3_io_regs
    import lc3_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_rd,
    input  logic        i_wr,
    input  logic [15:0] i_addr,
    input  logic [15:0] i_wdata,
    output logic [15:0] o_rdata,
    input  logic        i_kb_valid,
    input  logic [7:0]  i_kb_data,
    output logic        o_kb_ready,
    output logic        o_kb_irq,
    output logic        o_dsp_valid,
    output logic [7:0]  o_dsp_data,
    input  logic        i_dsp_ready
);
    logic        r_kb_full;
    logic        r_kb_ie;
    logic [7:0]  r_kbdr;
    logic        r_dsr_rdy;
    logic [15:0] r_ddr;
    logic        r_dsp_valid;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_kb_full   <= 1'b0;
            r_kb_ie     <= 1'b0;
            r_kbdr      <= 8'h00;
            r_dsr_rdy   <= 1'b1;
            r_ddr       <= 16'h0000;
            r_dsp_valid <= 1'b0;
        end else begin
            // A char can only be accepted while empty, so it never races a KBDR read clear.
            if (i_kb_valid && !r_kb_full) begin
                r_kb_full <= 1'b1;
                r_kbdr    <= i_kb_data;
            end else if (i_rd && i_addr == KBDR_ADDR)
                r_kb_full <= 1'b0;
            if (i_wr && i_addr == KBSR_ADDR)
                r_kb_ie <= i_wdata[14];
            // DDR writes while the display is busy are dropped.
            if (i_wr && i_addr == DDR_ADDR && r_dsr_rdy) begin
                r_ddr       <= i_wdata;
                r_dsp_valid <= 1'b1;
                r_dsr_rdy   <= 1'b0;
            end else if (r_dsp_valid && i_dsp_ready) begin
                r_dsp_valid <= 1'b0;
                r_dsr_rdy   <= 1'b1;
            end
        end
    end

    assign o_rdata = (i_addr == KBSR_ADDR) ? {r_kb_full, r_kb_ie, 14'b0} :
                     (i_addr == KBDR_ADDR) ? {8'h00, r_kbdr} :
                     (i_addr == DSR_ADDR)  ? {r_dsr_rdy, 15'b0} :
                     (i_addr == DDR_ADDR)  ? r_ddr : 16'h0000;
    assign o_kb_ready  = ~r_kb_full;
    assign o_kb_irq    = r_kb_full & r_kb_ie;
    assign o_dsp_valid = r_dsp_valid;
    assign o_dsp_data  = r_ddr[7:0];
endmodule

// File: rtl/lc3_memctl.sv
// lc3_memctl: LC-3 memory/IO controller serving datapath MAR/MDR cycles with a ready (R) pulse.
// Ports: clk, rst (async active-low); mem_en/mem_we/mar/mdr_in request, mem_rdata/mem_r completion;
//        kb_valid/kb_data/kb_ready/kb_irq keyboard stream; dsp_valid/dsp_data/dsp_ready display stream.
module lc3_memctl
    import lc3_pkg::*;
#(
    parameter int    MEM_DEPTH   = 65536,
    parameter int    WAIT_STATES = 2,
    parameter string INIT_FILE   = ""
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_en,
    input  logic        mem_we,
    input  logic [15:0] mar,
    input  logic [15:0] mdr_in,
    output logic [15:0] mem_rdata,
    output logic        mem_r,
    input  logic        kb_valid,
    input  logic [7:0]  kb_data,
    output logic        kb_ready,
    output logic        dsp_valid,
    output logic [7:0]  dsp_data,
    input  logic        dsp_ready,
    output logic        kb_irq
);
    localparam int AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    state_t       r_state;
    state_t       w_next;
    logic [3:0]   r_cnt;
    logic [15:0]  r_addr;
    logic [15:0]  r_wdata;
    logic         r_we;
    logic         r_io;
    logic [15:0]  r_rdata;
    logic [15:0]  r_mem [MEM_DEPTH];
    logic         w_io_req;
    logic         w_ram_go;
    logic [15:0]  w_acc_addr;
    logic [15:0]  w_acc_data;
    logic         w_acc_we;
    logic [AW-1:0] w_idx;
    logic [15:0]  w_io_rdata;

    assign w_io_req = mar >= IO_BASE;
    // With zero wait states the RAM is accessed straight from IDLE using the live request.
    assign w_ram_go = rst && ((r_state == IDLE && mem_en && !w_io_req && WAIT_STATES == 0) ||
                              (r_state == WAIT && r_cnt == 4'd1));
    assign w_acc_addr = (r_state == IDLE) ? mar : r_addr;
    assign w_acc_data = (r_state == IDLE) ? mdr_in : r_wdata;
    assign w_acc_we   = (r_state == IDLE) ? mem_we : r_we;
    assign w_idx      = AW'({16'h0000, w_acc_addr} % 32'(MEM_DEPTH));

    always_comb begin
        w_next = r_state;
        if (r_state == IDLE && mem_en)
            w_next = (w_io_req || WAIT_STATES == 0) ? DONE : WAIT;
        else if (r_state == WAIT && r_cnt == 4'd1)
            w_next = DONE;
        else if (r_state == DONE)
            w_next = IDLE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_cnt   <= 4'd0;
            r_addr  <= 16'h0000;
            r_wdata <= 16'h0000;
            r_we    <= 1'b0;
            r_io    <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && mem_en) begin
                r_addr  <= mar;
                r_wdata <= mdr_in;
                r_we    <= mem_we;
                r_io    <= w_io_req;
                r_cnt   <= 4'(WAIT_STATES);
            end else if (r_state == WAIT)
                r_cnt <= r_cnt - 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_ram_go) begin
            if (w_acc_we)
                r_mem[w_idx] <= w_acc_data;
            r_rdata <= w_acc_we ? 16'h0000 : r_mem[w_idx];
        end
    end

    lc3_io_regs u_io (
        .clk         (clk),
        .rst         (rst),
        .i_rd        (r_state == DONE && r_io && !r_we),
        .i_wr        (r_state == DONE && r_io && r_we),
        .i_addr      (r_addr),
        .i_wdata     (r_wdata),
        .o_rdata     (w_io_rdata),
        .i_kb_valid  (kb_valid),
        .i_kb_data   (kb_data),
        .o_kb_ready  (kb_ready),
        .o_kb_irq    (kb_irq),
        .o_dsp_valid (dsp_valid),
        .o_dsp_data  (dsp_data),
        .i_dsp_ready (dsp_ready)
    );

    // Device reads are taken live in DONE so status reflects register state at that cycle.
    assign mem_r     = r_state == DONE;
    assign mem_rdata = (r_state != DONE) ? 16'h0000 : (r_io && !r_we) ? w_io_rdata : r_io ? 16'h0000 : r_rdata;
endmodule
